// File: rtl/rvga_lsu_align.sv
// rvga_lsu_align
// Load/store alignment unit. It accepts one load or store request at a time
// and turns it into one or two NB-aligned memory beats. It drives the byte
// lanes for each beat, shifts store data into position, rebuilds load data
// across beats, and sign- or zero-extends the load result.
//
// Parameters
//   XLEN      data/address width (32 or 64)
//   SPLIT_EN  1: split an access that crosses a word boundary into two beats
//             0: report such an access as an error
//
// Ports
//   clk, rst_n                      clock, async active-low reset
//   req_v_i / req_ready_o           request handshake (ready only when idle)
//   req_ld_i, funct3_i              load/store select, rvga ldop/strop code
//   addr_i, wdata_i, rd_i           byte address, low-justified store data, tag
//   mem_v_o / mem_ready_i           memory beat handshake
//   mem_w_o, mem_addr_o             write beat flag, NB-aligned beat address
//   mem_wdata_o, mem_wmask_o        lane-shifted store data, active byte lanes
//   mem_rvalid_i, mem_rdata_i       load data return
//   resp_v_o / resp_ready_i         completion handshake
//   resp_data_o, resp_rd_o          extended load result (0 for stores), tag
//   resp_err_o                      illegal funct3 or unsplittable misalignment
module rvga_lsu_align #(
  parameter int XLEN     = 32,
  parameter int SPLIT_EN = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_v_i,
  output logic              req_ready_o,
  input  logic              req_ld_i,
  input  logic [2:0]        funct3_i,
  input  logic [XLEN-1:0]   addr_i,
  input  logic [XLEN-1:0]   wdata_i,
  input  logic [4:0]        rd_i,
  output logic              mem_v_o,
  input  logic              mem_ready_i,
  output logic              mem_w_o,
  output logic [XLEN-1:0]   mem_addr_o,
  output logic [XLEN-1:0]   mem_wdata_o,
  output logic [XLEN/8-1:0] mem_wmask_o,
  input  logic              mem_rvalid_i,
  input  logic [XLEN-1:0]   mem_rdata_i,
  output logic              resp_v_o,
  input  logic              resp_ready_i,
  output logic [XLEN-1:0]   resp_data_o,
  output logic [4:0]        resp_rd_o,
  output logic              resp_err_o
);

  localparam int NB   = XLEN / 8;
  localparam int OFFW = $clog2(NB);
  localparam int NB2  = 2 * NB;
  localparam int XW2  = 2 * XLEN;
  // Wide enough to hold off + size without overflow.
  localparam int SW   = OFFW + 2;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_REQ0  = 3'd1;
  localparam logic [2:0] S_WAIT0 = 3'd2;
  localparam logic [2:0] S_REQ1  = 3'd3;
  localparam logic [2:0] S_WAIT1 = 3'd4;
  localparam logic [2:0] S_RESP  = 3'd5;

  // Registered access state
  logic [2:0]      state_q;
  logic            ld_q;
  logic            sgn_q;
  logic [2:0]      size_q;
  logic [OFFW-1:0] off_q;
  logic            cross_q;
  logic            err_q;
  logic [XLEN-1:0] base_q;
  logic [NB2-1:0]  wmask_q;   // lanes for both beats: [NB-1:0] beat 0, upper half beat 1
  logic [XW2-1:0]  wdata_q;   // store data laid out the same way
  logic [4:0]      rd_q;
  logic [XLEN-1:0] rlo_q;     // beat-0 load data held while beat 1 is fetched
  logic [XLEN-1:0] rdata_q;

  // Decode of the incoming request
  logic [2:0]      acc_size;
  logic            acc_sgn;
  logic            acc_ill;
  logic [OFFW-1:0] acc_off;
  logic [SW-1:0]   acc_end;
  logic            acc_cross;
  logic            acc_err;
  logic [NB-1:0]   acc_lanes;
  logic [XLEN-1:0] acc_wd;
  logic [NB2-1:0]  acc_wmask;
  logic [XW2-1:0]  acc_wide;

  // Extract the accessed bytes from a two-beat little-endian window and
  // extend them to XLEN. The signed cast performs the sign extension; sgn=0
  // forces a zero top bit so the same cast zero-extends.
  function automatic logic [XLEN-1:0] load_ext(
    input logic [XW2-1:0]  raw,
    input logic [OFFW-1:0] off,
    input logic [2:0]      size,
    input logic            sgn
  );
    logic [XLEN-1:0] sh;
    sh = XLEN'(raw >> {off, 3'b000});
    case (size)
      3'd1:    load_ext = XLEN'($signed({sgn & sh[7],  sh[7:0]}));
      3'd2:    load_ext = XLEN'($signed({sgn & sh[15], sh[15:0]}));
      default: load_ext = XLEN'($signed({sgn & sh[31], sh[31:0]}));
    endcase
  endfunction

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path through the case statements can leave it unassigned and infer a latch.
  always_comb begin
    acc_size = 3'd1;
    acc_sgn  = 1'b0;
    acc_ill  = 1'b0;
    if (req_ld_i) begin
      case (funct3_i)
        3'd0: begin acc_size = 3'd1; acc_sgn = 1'b1; end  // lb
        3'd1: begin acc_size = 3'd2; acc_sgn = 1'b1; end  // lh
        3'd2: begin acc_size = 3'd4; acc_sgn = 1'b1; end  // lw
        3'd4: acc_size = 3'd1;                            // lbu
        3'd5: acc_size = 3'd2;                            // lhu
        default: acc_ill = 1'b1;
      endcase
    end else begin
      case (funct3_i)
        3'd0: acc_size = 3'd1;                            // sb
        3'd1: acc_size = 3'd2;                            // sh
        3'd2: acc_size = 3'd4;                            // sw
        default: acc_ill = 1'b1;
      endcase
    end

    acc_off   = addr_i[OFFW-1:0];
    acc_end   = SW'(acc_off) + SW'(acc_size);
    acc_cross = acc_end > SW'(NB);
    acc_err   = acc_ill || (acc_cross && (SPLIT_EN == 0));

    acc_lanes    = '0;
    acc_lanes[0] = 1'b1;
    if (acc_size != 3'd1) acc_lanes[1]   = 1'b1;
    if (acc_size == 3'd4) acc_lanes[3:2] = 2'b11;

    // Keep only the bytes being stored so unused lanes never carry stale data.
    acc_wd = '0;
    for (int i = 0; i < NB; i++) begin
      acc_wd[i*8 +: 8] = acc_lanes[i] ? wdata_i[i*8 +: 8] : 8'h00;
    end

    acc_wmask = NB2'(acc_lanes) << acc_off;
    acc_wide  = XW2'(acc_wd) << {acc_off, 3'b000};
  end

  // NOTE: all state, including the data/mask/address registers, is reset so
  // the outputs come out of reset at a known zero rather than X.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ld_q    <= 1'b0;
      sgn_q   <= 1'b0;
      size_q  <= 3'd0;
      off_q   <= '0;
      cross_q <= 1'b0;
      err_q   <= 1'b0;
      base_q  <= '0;
      wmask_q <= '0;
      wdata_q <= '0;
      rd_q    <= '0;
      rlo_q   <= '0;
      rdata_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values regardless of statement order.
      case (state_q)
        S_IDLE: begin
          if (req_v_i) begin
            ld_q    <= req_ld_i;
            sgn_q   <= acc_sgn;
            size_q  <= acc_size;
            off_q   <= acc_off;
            cross_q <= acc_cross;
            err_q   <= acc_err;
            base_q  <= {addr_i[XLEN-1:OFFW], {OFFW{1'b0}}};
            wmask_q <= acc_wmask;
            wdata_q <= acc_wide;
            rd_q    <= rd_i;
            rlo_q   <= '0;
            rdata_q <= '0;
            state_q <= acc_err ? S_RESP : S_REQ0;
          end
        end

        S_REQ0: begin
          if (mem_ready_i) begin
            if (ld_q)         state_q <= S_WAIT0;
            else if (cross_q) state_q <= S_REQ1;
            else              state_q <= S_RESP;
          end
        end

        S_WAIT0: begin
          if (mem_rvalid_i) begin
            if (cross_q) begin
              rlo_q   <= mem_rdata_i;
              state_q <= S_REQ1;
            end else begin
              rdata_q <= load_ext({{XLEN{1'b0}}, mem_rdata_i}, off_q, size_q, sgn_q);
              state_q <= S_RESP;
            end
          end
        end

        S_REQ1: begin
          if (mem_ready_i) state_q <= ld_q ? S_WAIT1 : S_RESP;
        end

        S_WAIT1: begin
          if (mem_rvalid_i) begin
            rdata_q <= load_ext({mem_rdata_i, rlo_q}, off_q, size_q, sgn_q);
            state_q <= S_RESP;
          end
        end

        S_RESP: begin
          if (resp_ready_i) state_q <= S_IDLE;
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  logic beat1;
  assign beat1 = (state_q == S_REQ1) || (state_q == S_WAIT1);

  assign req_ready_o = (state_q == S_IDLE);
  assign mem_v_o     = (state_q == S_REQ0) || (state_q == S_REQ1);
  assign mem_w_o     = mem_v_o && !ld_q;
  assign mem_addr_o  = beat1 ? base_q + XLEN'(NB) : base_q;
  assign mem_wdata_o = beat1 ? wdata_q[XW2-1:XLEN] : wdata_q[XLEN-1:0];
  assign mem_wmask_o = beat1 ? wmask_q[NB2-1:NB] : wmask_q[NB-1:0];
  assign resp_v_o    = (state_q == S_RESP);
  assign resp_data_o = rdata_q;
  assign resp_rd_o   = rd_q;
  assign resp_err_o  = resp_v_o && err_q;

endmodule
